writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
// - Final pipeline stage; the producer end of the decode-stage regfile write port (ld_regfile, rd, write data).
// - Accepts one retiring instruction per handshake from the MEM stage.
// - For loads, waits for the data-cache response, then extracts the byte/half/word and sign- or zero-extends it.
// - Selects the write-back source and drives a registered, single-cycle regfile write pulse.
// PARAMETERS
// - XLEN      32  datapath width; only 32 is supported.
// - CNT_W     64  width of the retired-instruction counter (used only with WB_INSTRET_EN).
// PORTS
// - clk          in   1      clock; all state updates on the rising edge.
// - rst          in   1      synchronous, active-high reset.
// - in_valid     in   1      MEM stage presents an instruction.
// - in_ready     out  1      stage can accept; transfer happens when in_valid && in_ready at a rising edge.
// - in_pc        in   32     instruction PC.
// - in_rd        in   5      destination register index.
// - in_alu       in   32     ALU result; for loads, the effective address.
// - in_u_imm     in   32     U-type immediate.
// - in_funct3    in   3      load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
// - in_wb_sel    in   2      write source: 00 alu, 01 mem, 10 pc+4, 11 u_imm.
// - in_load_rf   in   1      instruction writes rd.
// - dmem_resp    in   1      data-cache response strobe for the outstanding load.
// - dmem_rdata   in   32     data-cache read word, aligned to a 4-byte boundary.
// - ld_regfile   out  1      regfile write enable; one-cycle pulse.
// - rd           out  5      regfile write index.
// - regfile_in   out  32     regfile write data.
// - retire       out  1      one-cycle pulse per completed instruction.
// - instret      out  CNT_W  retired-instruction count.
// BEHAVIOUR
// - FSM states: IDLE, WAIT_MEM. Reset enters IDLE.
// - in_ready = !rst && state==IDLE.
// - IDLE, accept, wb_sel!=01: capture the result; ld_regfile/retire assert in the next cycle only (latency 1).
// - IDLE, accept, wb_sel==01, dmem_resp=1 in the same cycle: use dmem_rdata immediately; latency 1.
// - IDLE, accept, wb_sel==01, dmem_resp=0: latch pc/rd/alu[1:0]/funct3/load_rf; go to WAIT_MEM.
// - WAIT_MEM, dmem_resp=1: extract data; write pulse in the next cycle; return to IDLE.
//   - Next instruction can be accepted no earlier than the cycle of the write pulse.
// - dmem_resp while IDLE with no load being accepted: ignored; no state change.
// - Load extraction, offset = alu[1:0]:
//   - LB/LBU: byte at offset.
//   - LH/LHU: halfword at alu[1]*16; alu[0] is ignored.
//   - LW: full word; offset ignored.
//   - Signed forms sign-extend from bit 7/15; unsigned forms zero-extend.
//   - Other funct3 values: treat as LW.
// - pc+4 wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
// - rd==0 or load_rf=0: ld_regfile stays 0; retire still pulses; regfile_in holds the computed value.
// - Output updates:
//   - rd and regfile_in update only on a completing instruction; otherwise they hold their last value.
//   - ld_regfile and retire are 0 on every cycle with no completion.
// - Reset values: ld_regfile=0, retire=0, rd=0, regfile_in=0, instret=0, state=IDLE.
// - rst asserted in WAIT_MEM: the pending load is dropped with no write pulse; a dmem_resp in that cycle is ignored.
// CONFIGURATION
// - WB_INSTRET_EN defined:
//   - instret increments by 1 on every retire pulse, including rd==0 writes.
//   - Wraps at 2^CNT_W-1 -> 0; cleared by rst.
// - WB_INSTRET_EN undefined: instret is tied to 0; no counter flops are built.
// TESTING
// - ADD-type, wb_sel=00, rd=5, alu=0x1234 -> next cycle ld_regfile=1, rd=5, regfile_in=0x1234, retire=1.
// - LB, alu=...03, dmem_rdata=0x80FF_1122 returned 3 cycles after accept -> in_ready=0 until resp;
//   regfile_in=0xFFFF_FF80 one cycle after resp.
// - LHU, alu=...02, rdata=0xBEEF_0000, resp in the same cycle as accept -> regfile_in=0x0000_BEEF, latency 1.
// - JAL, wb_sel=10, pc=0xFFFF_FFFC -> regfile_in=0x0000_0000.
// - LUI, rd=0, u_imm=0xABCDE000 -> ld_regfile=0, retire=1.
// - rst asserted while in WAIT_MEM, dmem_resp in the same cycle -> no write pulse; in_ready=1 after rst drops.
// - With WB_INSTRET_EN: 10 back-to-back ALU ops -> instret=10. Without it: instret=0 throughout.

Source files
------------

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// writeback_stage: final pipeline stage; load extraction and a registered
// single-cycle regfile write. Optional retired-instruction counter: WB_INSTRET_EN.
// Revision 1.0
// ============================================================================
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [4:0]       in_rd,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_u_imm,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_wb_sel,
  input  logic             in_load_rf,
  input  logic             dmem_resp,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             ld_regfile,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  regfile_in,
  output logic             retire,
  output logic [CNT_W-1:0] instret
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_MEM = 1'b1;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  logic [0:0]      state, state_nxt;
  logic [4:0]      pend_rd;
  logic [1:0]      pend_off;
  logic [2:0]      pend_funct3;
  logic            pend_load_rf;
  logic            accept, complete, wr_en;
  logic [4:0]      wr_rd;
  logic [XLEN-1:0] wr_data;

  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3,
                                                   input logic [1:0] off,
                                                   input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_extract = {{(XLEN-8){b[7]}}, b};
      3'b100:  load_extract = {{(XLEN-8){1'b0}}, b};
      3'b001:  load_extract = {{(XLEN-16){h[15]}}, h};
      3'b101:  load_extract = {{(XLEN-16){1'b0}}, h};
      default: load_extract = w;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept && in_wb_sel == WB_MEM && !dmem_resp) state_nxt = WAIT_MEM;
      WAIT_MEM: if (dmem_resp) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = !rst && (state == IDLE);
    accept   = in_valid && in_ready;
    complete = 1'b0;
    wr_en    = 1'b0;
    wr_rd    = in_rd;
    wr_data  = in_alu;
    if (state == WAIT_MEM) begin
      // rst gates completion so a response during reset cannot write
      complete = dmem_resp && !rst;
      wr_en    = pend_load_rf;
      wr_rd    = pend_rd;
      wr_data  = load_extract(pend_funct3, pend_off, dmem_rdata);
    end else begin
      complete = accept && (in_wb_sel != WB_MEM || dmem_resp);
      wr_en    = in_load_rf;
      case (in_wb_sel)
        WB_ALU:  wr_data = in_alu;
        WB_MEM:  wr_data = load_extract(in_funct3, in_alu[1:0], dmem_rdata);
        WB_PC4:  wr_data = in_pc + 32'd4;
        default: wr_data = in_u_imm;
      endcase
    end
  end

  // Load context held while the data cache is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_rd      <= '0;
      pend_off     <= '0;
      pend_funct3  <= '0;
      pend_load_rf <= 1'b0;
    end else if (accept) begin
      pend_rd      <= in_rd;
      pend_off     <= in_alu[1:0];
      pend_funct3  <= in_funct3;
      pend_load_rf <= in_load_rf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_regfile <= 1'b0;
      retire     <= 1'b0;
      rd         <= '0;
      regfile_in <= '0;
    end else begin
      ld_regfile <= complete && wr_en && (wr_rd != 5'd0);
      retire     <= complete;
      if (complete) begin
        rd         <= wr_rd;
        regfile_in <= wr_data;
      end
    end
  end

`ifdef WB_INSTRET_EN
  always_ff @(posedge clk) begin
    if (rst)           instret <= '0;
    else if (complete) instret <= instret + 1'b1;
  end
`else
  assign instret = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// tb_writeback_stage: directed vectors with hand-computed expectations.
module tb_writeback_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_alu, in_u_imm, dmem_rdata, regfile_in;
  logic [4:0]  in_rd, rd;
  logic [2:0]  in_funct3;
  logic [1:0]  in_wb_sel;
  logic        in_load_rf, dmem_resp, ld_regfile, retire;
  logic [63:0] instret;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rd(in_rd), .in_alu(in_alu), .in_u_imm(in_u_imm),
    .in_funct3(in_funct3), .in_wb_sel(in_wb_sel), .in_load_rf(in_load_rf),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .ld_regfile(ld_regfile),
    .rd(rd), .regfile_in(regfile_in), .retire(retire), .instret(instret)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [2:0] f3, input logic [4:0] r,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] uimm);
    in_valid   = 1'b1;
    in_wb_sel  = sel;
    in_funct3  = f3;
    in_rd      = r;
    in_alu     = alu;
    in_pc      = pc;
    in_u_imm   = uimm;
    in_load_rf = 1'b1;
  endtask

  initial begin
    logic [63:0] exp_instret;
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_rd = '0; in_alu = '0; in_u_imm = '0;
    in_funct3 = '0; in_wb_sel = '0; in_load_rf = 1'b0; dmem_resp = 1'b0; dmem_rdata = '0;
    step(); step();
    check_val("rst_ld", ld_regfile, 0);
    check_val("rst_retire", retire, 0);
    check_val("rst_rd", rd, 0);
    check_val("rst_data", regfile_in, 0);
    check_val("rst_instret", instret, 0);
    check_val("rst_ready", in_ready, 0);
    rst = 1'b0;
    #1 check_val("ready_after_rst", in_ready, 1);

    // ALU op
    issue(2'b00, 3'b000, 5'd5, 32'h0000_1234, 32'h100, 32'h0);
    step(); in_valid = 1'b0;
    check_val("add_ld", ld_regfile, 1);
    check_val("add_rd", rd, 5);
    check_val("add_data", regfile_in, 32'h1234);
    check_val("add_retire", retire, 1);
    step();
    check_val("add_ld_drop", ld_regfile, 0);
    check_val("add_retire_drop", retire, 0);
    check_val("add_data_hold", regfile_in, 32'h1234);

    // LB with response 3 cycles after accept
    issue(2'b01, 3'b000, 5'd7, 32'h0000_0103, 32'h104, 32'h0);
    dmem_rdata = 32'hDEAD_BEEF;
    step(); in_valid = 1'b0;
    check_val("lb_wait_ready0", in_ready, 0);
    check_val("lb_wait_retire0", retire, 0);
    step();
    check_val("lb_wait_ready1", in_ready, 0);
    step();
    check_val("lb_wait_ready2", in_ready, 0);
    check_val("lb_wait_rd_hold", rd, 5);
    dmem_resp = 1'b1; dmem_rdata = 32'h80FF_1122;
    step(); dmem_resp = 1'b0;
    check_val("lb_ld", ld_regfile, 1);
    check_val("lb_rd", rd, 7);
    check_val("lb_data", regfile_in, 32'hFFFF_FF80);
    check_val("lb_ready", in_ready, 1);

    // LHU, response in the accept cycle
    issue(2'b01, 3'b101, 5'd9, 32'h0000_0002, 32'h108, 32'h0);
    dmem_resp = 1'b1; dmem_rdata = 32'hBEEF_0000;
    step(); in_valid = 1'b0; dmem_resp = 1'b0;
    check_val("lhu_data", regfile_in, 32'h0000_BEEF);
    check_val("lhu_ld", ld_regfile, 1);
    check_val("lhu_ready", in_ready, 1);

    // LH with alu[0] set: offset bit 0 ignored, sign-extended
    issue(2'b01, 3'b001, 5'd10, 32'h0000_0001, 32'h10C, 32'h0);
    dmem_resp = 1'b1; dmem_rdata = 32'h1234_8001;
    step();
    check_val("lh_data", regfile_in, 32'hFFFF_8001);
    // LBU offset 2, back-to-back
    issue(2'b01, 3'b100, 5'd11, 32'h0000_0006, 32'h110, 32'h0);
    dmem_rdata = 32'h00AB_0000;
    step();
    check_val("lbu_data", regfile_in, 32'h0000_00AB);
    // funct3 011 behaves as LW
    issue(2'b01, 3'b011, 5'd12, 32'h0000_0003, 32'h114, 32'h0);
    dmem_rdata = 32'hCAFE_F00D;
    step(); in_valid = 1'b0; dmem_resp = 1'b0;
    check_val("lw_dflt_data", regfile_in, 32'hCAFE_F00D);

    // JAL pc+4 wrap
    issue(2'b10, 3'b000, 5'd1, 32'h0, 32'hFFFF_FFFC, 32'h0);
    step(); in_valid = 1'b0;
    check_val("jal_data", regfile_in, 32'h0);
    check_val("jal_ld", ld_regfile, 1);

    // LUI to x0
    issue(2'b11, 3'b000, 5'd0, 32'h0, 32'h0, 32'hABCD_E000);
    step(); in_valid = 1'b0;
    check_val("lui_x0_ld", ld_regfile, 0);
    check_val("lui_x0_retire", retire, 1);
    check_val("lui_x0_data", regfile_in, 32'hABCD_E000);

    // load_rf=0 still retires without writing
    issue(2'b00, 3'b000, 5'd3, 32'h55, 32'h0, 32'h0);
    in_load_rf = 1'b0;
    step(); in_valid = 1'b0;
    check_val("norf_ld", ld_regfile, 0);
    check_val("norf_retire", retire, 1);
    check_val("norf_rd", rd, 3);

    // stray response while idle
    dmem_resp = 1'b1; dmem_rdata = 32'h1111_1111;
    step(); dmem_resp = 1'b0;
    check_val("stray_retire", retire, 0);
    check_val("stray_ready", in_ready, 1);
    check_val("stray_data_hold", regfile_in, 32'h55);

    // reset while waiting, response in the reset cycle
    issue(2'b01, 3'b010, 5'd4, 32'h0, 32'h0, 32'h0);
    step(); in_valid = 1'b0;
    check_val("rstwait_ready0", in_ready, 0);
    rst = 1'b1; dmem_resp = 1'b1; dmem_rdata = 32'h7777_7777;
    step(); rst = 1'b0; dmem_resp = 1'b0;
    check_val("rstwait_ld", ld_regfile, 0);
    check_val("rstwait_retire", retire, 0);
    #1 check_val("rstwait_ready", in_ready, 1);
    step();
    check_val("rstwait_retire_after", retire, 0);
    check_val("rstwait_data", regfile_in, 0);

    // 10 back-to-back ALU ops
    for (int i = 0; i < 10; i++) begin
      issue(2'b00, 3'b000, 5'd2, 32'(i + 1), 32'h0, 32'h0);
      step();
      check_val("b2b_retire", retire, 1);
    end
    in_valid = 1'b0;
    check_val("b2b_last_data", regfile_in, 32'd10);
`ifdef WB_INSTRET_EN
    exp_instret = 64'd10;
`else
    exp_instret = 64'd0;
`endif
    check_val("instret", instret, exp_instret);
    step();
    check_val("instret_hold", instret, exp_instret);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
